// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants and width helper
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Bits needed to hold 0..value-1; never less than 1 so it can size a vector.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        if (res < 1) begin
            res = 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// rtl/pixel_tick_div.sv - clk-to-pixel divider producing a one-clk pixel strobe
module pixel_tick_div
    import vga_timing_pkg::*;
#(
    parameter int PIX_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic pixel_tick
);

    localparam int            DW   = clog2(PIX_DIV);
    localparam logic [DW-1:0] LAST = DW'(PIX_DIV - 1);

    logic [DW-1:0] div_cnt;

    // Phase counter 0..PIX_DIV-1; holds while disabled so a resumed pixel keeps its phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    assign pixel_tick = en && (div_cnt == LAST);

endmodule

// File: rtl/vga_sync_timing_gen.sv
// rtl/vga_sync_timing_gen.sv - VGA pixel counters, syncs, video_on and pixel strobe
module vga_sync_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIX_DIV  = 4,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = clog2(H_TOTAL),
    localparam int VW      = clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          pixel_tick,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [HW-1:0] pixel_x,
    output logic [VW-1:0] pixel_y,
    output logic          line_end,
    output logic          frame_end
);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam int            HS_START = H_ACTIVE + H_FP;
    localparam int            HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int            VS_START = V_ACTIVE + V_FP;
    localparam int            VS_END   = V_ACTIVE + V_FP + V_SYNC;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic          hs_act;
    logic          vs_act;
    logic          von_nxt;

    pixel_tick_div #(
        .PIX_DIV (PIX_DIV)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pixel_tick (pixel_tick)
    );

    // Next counter position and its decode; outputs are registered from these so they line up with the counters.
    always_comb begin
        h_nxt = h_cnt;
        v_nxt = v_cnt;
        if (pixel_tick) begin
            if (h_cnt == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_nxt = h_cnt + 1'b1;
            end
        end
        hs_act  = (int'(h_nxt) >= HS_START) && (int'(h_nxt) < HS_END);
        vs_act  = (int'(v_nxt) >= VS_START) && (int'(v_nxt) < VS_END);
        von_nxt = (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
    end

    // Counter and output registers; reset wins over en and drops any sync pulse in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            hsync    <= ~SYNC_POL;
            vsync    <= ~SYNC_POL;
            video_on <= 1'b0;
        end else if (en) begin
            h_cnt    <= h_nxt;
            v_cnt    <= v_nxt;
            hsync    <= hs_act ? SYNC_POL : ~SYNC_POL;
            vsync    <= vs_act ? SYNC_POL : ~SYNC_POL;
            video_on <= von_nxt;
        end
    end

    assign pixel_x   = h_cnt;
    assign pixel_y   = v_cnt;
    assign line_end  = pixel_tick && (h_cnt == H_LAST);
    assign frame_end = line_end && (v_cnt == V_LAST);

endmodule
